// File: rtl/fifo_wr_arbiter.sv
// Packet round-robin arbiter for the TX FIFO write port; FIFO_WR_ARB_HDR_EN adds a channel-ID header word per packet.
// Latency: first FIFO write 1 clk after a request is seen in IDLE; data beats pass straight through in DATA.
// Backpressure: fifo_full stalls header and data (req_ready low); a silent granted requester keeps the grant.
module fifo_wr_arbiter #(
   parameter int                    NUM_REQ    = 4,
   parameter int                    FIFO_WIDTH = 8,
   parameter logic [FIFO_WIDTH-1:0] HDR_TAG    = FIFO_WIDTH'(8'hA0)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]         fifo_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);
   localparam int IDW = $clog2(NUM_REQ);

`ifdef FIFO_WR_ARB_HDR_EN
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

   state_t                state, state_nxt;
   logic [IDW-1:0]        last_grant;
   logic [IDW-1:0]        pick_id;
   logic                  pick_vld;
   logic                  pkt_done;
   logic [FIFO_WIDTH-1:0] req_data_arr [NUM_REQ];
   logic [FIFO_WIDTH-1:0] gnt_data;
   logic                  gnt_vld;
   logic                  gnt_last;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
      assign req_data_arr[k] = req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
   end

   assign gnt_data = req_data_arr[grant_id];
   assign gnt_vld  = req_valid[grant_id];
   assign gnt_last = req_last[grant_id];

`ifdef FIFO_WR_ARB_HDR_EN
   logic [FIFO_WIDTH-1:0] hdr_word;
   assign hdr_word = {HDR_TAG[FIFO_WIDTH-1:IDW], grant_id};
`else
   logic unused_hdr_tag;
   assign unused_hdr_tag = ^HDR_TAG;
`endif

   // Search starts just after the last completed grant and wraps once around.
   always_comb begin
      int             cand;
      logic [IDW-1:0] cand_id;
      pick_vld = 1'b0;
      pick_id  = '0;
      cand     = 0;
      cand_id  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_id = IDW'(cand);
         if (!pick_vld && req_valid[cand_id]) begin
            pick_vld = 1'b1;
            pick_id  = cand_id;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      pkt_done     = 1'b0;
      case (state)
         IDLE: begin
`ifdef FIFO_WR_ARB_HDR_EN
            if (pick_vld) state_nxt = HDR;
`else
            if (pick_vld) state_nxt = DATA;
`endif
         end
`ifdef FIFO_WR_ARB_HDR_EN
         HDR: begin
            fifo_wr_en   = !fifo_full;
            fifo_wr_data = hdr_word;
            if (!fifo_full) state_nxt = DATA;
         end
`endif
         DATA: begin
            req_ready[grant_id] = !fifo_full;
            fifo_wr_en          = gnt_vld && !fifo_full;
            fifo_wr_data        = gnt_data;
            if (gnt_vld && !fifo_full && gnt_last) begin
               pkt_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= IDW'(NUM_REQ-1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_vld) grant_id <= pick_id;
         if (pkt_done) last_grant <= grant_id;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus randomized packets with valid gaps and FIFO-full stalls.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int W = 8;
`ifdef FIFO_WR_ARB_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           fifo_full;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_wr_data;
   logic [1:0]     grant_id;
   logic           busy;

   fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [W-1:0] dat [N][32];
   bit           lst [N][32];
   int           tot [N];
   int           ptr [N];
   int           mlast;
   logic [W-1:0] exp_q [$];
   logic [N-1:0] acc;
   bit           gaps, full_rand, full_force;
   int           checks = 0;
   int           failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_byte(input int k, input logic [W-1:0] b, input bit last);
      dat[k][tot[k]] = b;
      lst[k][tot[k]] = last;
      tot[k]++;
   endtask

   task automatic add_rand_pkt(input int k);
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), b == len - 1);
   endtask

   task automatic clear_loads();
      for (int k = 0; k < N; k++) begin
         tot[k] = 0;
         ptr[k] = 0;
      end
   endtask

   function automatic bit all_done();
      for (int k = 0; k < N; k++) if (ptr[k] != tot[k]) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: whole packets handed out round-robin among requesters that still have packets.
   task automatic build_model();
      int pos [N];
      int k;
      int c;
      for (int i = 0; i < N; i++) pos[i] = ptr[i];
      forever begin
         k = -1;
         for (int i = 1; i <= N; i++) begin
            c = (mlast + i) % N;
            if (k < 0 && pos[c] < tot[c]) k = c;
         end
         if (k < 0) break;
         if (HDR) exp_q.push_back(8'hA0 | 8'(k));
         do begin
            exp_q.push_back(dat[k][pos[k]]);
            pos[k]++;
         end while (!lst[k][pos[k]-1]);
         mlast = k;
      end
   endtask

   task automatic drive_inputs();
      bit has, start;
      for (int k = 0; k < N; k++) begin
         has   = ptr[k] < tot[k];
         start = (ptr[k] == 0) ? 1'b1 : lst[k][ptr[k]-1];
         req_valid[k]        = has && (start || !gaps || ($urandom_range(0, 3) != 0));
         req_data[k*W +: W]  = has ? dat[k][ptr[k]] : 8'($urandom);
         req_last[k]         = has ? lst[k][ptr[k]] : 1'($urandom);
      end
      fifo_full = full_force || (full_rand && ($urandom_range(0, 3) == 0));
   endtask

   // Called at a negedge: record handshakes, then move inputs just after the edge.
   task automatic adv();
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (acc[k]) ptr[k]++;
      drive_inputs();
   endtask

   task automatic tick();
      @(negedge clk);
      adv();
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((!all_done() || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!all_done() || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: %0d expected words still pending after %0d cycles", name, exp_q.size(), n);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      gaps       = 1'b0;
      full_rand  = 1'b0;
      full_force = 1'b0;
      clear_loads();
      drive_inputs();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      mlast = N - 1;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst) begin
         checks++;
         if ($countones(req_ready) > 1) begin
            failures++;
            $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
         end
         if (fifo_wr_en) begin
            checks++;
            if (fifo_full) begin
               failures++;
               $display("FAIL wr_while_full: got wr_en=1 expected 0 with fifo_full=1");
            end
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write: got data %0h expected no write", fifo_wr_data);
            end else begin
               e = exp_q.pop_front();
               if (fifo_wr_data !== e) begin
                  failures++;
                  $display("FAIL wr_data: got %0h expected %0h", fifo_wr_data, e);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Single packet from requester 2 with exact cycle timing.
      add_byte(2, 8'h11, 1'b0);
      add_byte(2, 8'h22, 1'b0);
      add_byte(2, 8'h33, 1'b1);
      build_model();
      drive_inputs();
      @(negedge clk);
      chk("t1_idle_wr_en", fifo_wr_en, 0);
      chk("t1_idle_busy", busy, 0);
      adv();
      for (int c = 0; c < (HDR ? 4 : 3); c++) begin
         @(negedge clk);
         chk("t1_wr_en", fifo_wr_en, 1);
         chk("t1_busy", busy, 1);
         chk("t1_grant", grant_id, 2);
         adv();
      end
      @(negedge clk);
      chk("t1_done_busy", busy, 0);
      chk("t1_done_wr_en", fifo_wr_en, 0);
      chk("t1_grant_hold", grant_id, 2);
      adv();
      chk("t1_exp_empty", exp_q.size(), 0);

      // Fairness: requesters 0 and 3 alternate two-beat packets.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         add_byte(0, 8'(8'h10 + 2*p), 1'b0);
         add_byte(0, 8'(8'h11 + 2*p), 1'b1);
         add_byte(3, 8'(8'h30 + 2*p), 1'b0);
         add_byte(3, 8'(8'h31 + 2*p), 1'b1);
      end
      build_model();
      drive_inputs();
      drain(100, "fair");
      clear_loads();
      drive_inputs();

      // Backpressure for 5 cycles in the middle of a DATA packet.
      for (int b = 1; b <= 6; b++) add_byte(0, 8'(b), b == 6);
      build_model();
      drive_inputs();
      for (int n = 0; n < 50 && ptr[0] != 2; n++) tick();
      chk("t3_reach", ptr[0], 2);
      full_force = 1'b1;
      drive_inputs();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t3_ready_stall", req_ready, 0);
         chk("t3_wr_en_stall", fifo_wr_en, 0);
         adv();
      end
      full_force = 1'b0;
      drive_inputs();
      drain(100, "bp");
      clear_loads();
      drive_inputs();

      // FIFO full when the grant is first taken: first word held, then written once.
      add_byte(3, 8'hC1, 1'b0);
      add_byte(3, 8'hC2, 1'b1);
      build_model();
      full_force = 1'b1;
      drive_inputs();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t4_wr_en_held", fifo_wr_en, 0);
         if (c > 0) chk("t4_busy_held", busy, 1);
         adv();
      end
      full_force = 1'b0;
      drive_inputs();
      drain(100, "hdrfull");
      clear_loads();
      drive_inputs();

      // Reset during beat 2 of requester 1, then a fresh 0-and-1 contest.
      for (int b = 0; b < 4; b++) add_byte(1, 8'(8'hE0 + b), b == 3);
      build_model();
      drive_inputs();
      for (int n = 0; n < 50 && ptr[1] != 1; n++) tick();
      chk("t5_reach", ptr[1], 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_loads();
      exp_q.delete();
      mlast = N - 1;
      drive_inputs();
      @(negedge clk);
      chk("t5_wr_en", fifo_wr_en, 0);
      chk("t5_ready", req_ready, 0);
      chk("t5_busy", busy, 0);
      chk("t5_grant", grant_id, 0);
      chk("t5_wr_data", fifo_wr_data, 0);
      adv();
      add_byte(1, 8'h66, 1'b0);
      add_byte(1, 8'h77, 1'b1);
      add_byte(0, 8'h55, 1'b1);
      build_model();
      drive_inputs();
      drain(100, "post_rst");
      clear_loads();
      drive_inputs();

      // Randomized rounds with mid-packet valid gaps and random FIFO-full.
      gaps      = 1'b1;
      full_rand = 1'b1;
      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < N; k++) begin
            int np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) add_rand_pkt(k);
         end
         build_model();
         drive_inputs();
         drain(2000, "rand");
         clear_loads();
         drive_inputs();
      end

      repeat (3) tick();
      chk("final_exp_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Packet-level round-robin arbiter that shares the write port of the FTDI engine's async TX FIFO among NUM_REQ requesters.
- Grants one requester per packet and prefixes each packet with a channel-ID header word.
- Streams the granted requester's data into the FIFO until its last beat.
- Sits in the write-clock domain, directly driving the FIFO's fifo_wr_en/fifo_wr_data and observing fifo_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- FIFO_WIDTH, 8, data word width; must be >= $clog2(NUM_REQ)+1.
- HDR_TAG, 8'hA0, header template; the low $clog2(NUM_REQ) bits are replaced by the granted ID.

Ports:
- clk  in  1  write-domain clock (same clock as the FIFO wr_clk)
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*FIFO_WIDTH  per-requester data; requester k occupies bits [k*FIFO_WIDTH +: FIFO_WIDTH]
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  FIFO_WIDTH  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  currently or last granted requester
- busy  out  1  high in HDR or DATA state

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.
  - grant_id=0.
  - Internal last_grant=NUM_REQ-1, so the first grant goes to requester 0.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register the pick into grant_id and go to HDR on the next clk.
  - If no request, stay in IDLE.
  - A one-cycle IDLE slot separates consecutive packets.
- HDR:
  - fifo_wr_en = !fifo_full.
  - fifo_wr_data = HDR_TAG with the low bits set to grant_id.
  - Go to DATA on the cycle the header is written; hold in HDR while fifo_full.
  - req_ready=0 throughout HDR.
- DATA:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - fifo_wr_en = req_valid[grant_id] && !fifo_full.
  - fifo_wr_data = req_data slice of grant_id.
  - Accepted beat with req_last[grant_id] set: last_grant<=grant_id, go to IDLE.
- fifo_wr_en, fifo_wr_data and req_ready are combinational from state, grant_id and fifo_full, so a write lands in the same cycle as acceptance. There are no bubbles while valid is high and the FIFO is not full.
- Never assert fifo_wr_en while fifo_full=1.
- The granted requester dropping req_valid mid-packet holds the grant. No writes occur and there is no timeout.
- req_valid and req_last on non-granted requesters are ignored outside IDLE.
- A single-beat packet (last on the first data beat) returns to IDLE after that beat.
- A requester asserting valid continuously is served again only after every other active requester has had one packet.
- rst mid-packet: immediate return to reset values next clk; the partial packet in the FIFO is not retracted.
- grant_id holds its value in IDLE until a new pick.

Optional Feature:
FIFO_WR_ARB_HDR_EN:
- Defined: HDR state present, and each packet is preceded by one header word as above.
- Undefined: no HDR state; IDLE goes directly to DATA and packets are written without a header. HDR_TAG is unused.
- Arbitration, ordering and all other behaviour are identical in both builds.

Test Plan:
1. Single packet: req_valid[2]=1, data 0x11,0x22,0x33 with last on 0x33, fifo_full=0 → FIFO receives 0xA2,0x11,0x22,0x33 on consecutive cycles starting 1 clk after valid; busy drops after 0x33.
2. Fairness: req 0 and req 3 continuously valid, 2-beat packets, after reset → grant order 0,3,0,3; headers 0xA0,0xA3 alternate; req_ready never has two bits high.
3. Backpressure: fifo_full=1 for 5 cycles in DATA mid-packet → fifo_wr_en=0 and req_ready=0 for those 5 cycles; no beat lost or duplicated after release.
4. Full on header: fifo_full=1 when entering HDR → header is held until full deasserts, then written exactly once.
5. Reset mid-packet: rst pulse for 1 clk during DATA beat 2 of requester 1 → next cycle state IDLE and all outputs 0; a fresh request from requester 1 is granted 0 first only if requester 0 is also valid, else 1.
6. Macro off (FIFO_WR_ARB_HDR_EN undefined): repeat scenario 1 → FIFO receives 0x11,0x22,0x33 only, starting 1 clk after valid.
